// File: rtl/md_issue_ctrl_pkg.sv
// Shared MUDIV definitions: opcode/funct encodings and default latencies.
package md_defs;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned CNT_W   = 4;

   localparam int unsigned DEF_MULT_LAT = 5;
   localparam int unsigned DEF_DIV_LAT  = 10;

   localparam logic [5:0] OP_SPECIAL  = 6'h00;
   localparam logic [5:0] OP_SPECIAL2 = 6'h1c;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1a;
   localparam logic [5:0] F_DIVU  = 6'h1b;
   localparam logic [5:0] F_MADD  = 6'h00;
   localparam logic [5:0] F_MADDU = 6'h01;

endpackage

// File: rtl/md_issue_ctrl_if.sv
// D->E issue bus between decode/hazard logic (master) and the MUDIV issue controller (slave).
interface md_issue_ctrl_if;
   import md_defs::*;

   logic [INSTR_W-1:0] instrD;
   logic               otherStall;
   logic [INSTR_W-1:0] instrE;
   logic               start;
   logic               busy;
   logic               mdStall;

   modport master (
      output instrD, otherStall,
      input  instrE, start, busy, mdStall
   );

   modport slave (
      input  instrD, otherStall,
      output instrE, start, busy, mdStall
   );
endinterface

// File: rtl/md_issue_ctrl_class_dec.sv
// Instruction class decoder for the MUDIV path: MD (starts MUDIV), HL (touches HI/LO), Div.
// madd/maddu join the MD class only when MD_MADD_EN is defined.
module md_class_dec
   import md_defs::*;
(
   input  logic [INSTR_W-1:0] i_instr,
   output logic               o_is_md,
   output logic               o_is_hl,
   output logic               o_is_div
);

   logic [5:0] w_op;
   logic [5:0] w_funct;
   logic       w_unused_fields;

   assign w_op            = i_instr[31:26];
   assign w_funct         = i_instr[5:0];
   assign w_unused_fields = ^i_instr[25:6];

   always_comb begin
      o_is_md  = 1'b0;
      o_is_hl  = 1'b0;
      o_is_div = 1'b0;
      if (w_op == OP_SPECIAL) begin
         case (w_funct)
            F_MULT, F_MULTU: o_is_md = 1'b1;
            F_DIV, F_DIVU: begin
               o_is_md  = 1'b1;
               o_is_div = 1'b1;
            end
            F_MFHI, F_MTHI, F_MFLO, F_MTLO: o_is_hl = 1'b1;
            default: ;
         endcase
      end
`ifdef MD_MADD_EN
      if ((w_op == OP_SPECIAL2) && ((w_funct == F_MADD) || (w_funct == F_MADDU)))
         o_is_md = 1'b1;
`endif
      // every MD instruction also writes HI/LO
      if (o_is_md)
         o_is_hl = 1'b1;
   end

endmodule

// File: rtl/md_issue_ctrl.sv
// D->E issue register for MUDIV: one-cycle start pulse, occupancy counter and HI/LO stall.
// Optional madd/maddu support is enabled with MD_MADD_EN (handled in md_class_dec).
module md_issue_ctrl
   import md_defs::*;
#(
   parameter int unsigned MULT_LAT = DEF_MULT_LAT,
   parameter int unsigned DIV_LAT  = DEF_DIV_LAT
) (
   input  logic           clk,
   input  logic           reset,
   md_issue_ctrl_if.slave bus
);

   logic [INSTR_W-1:0] r_instr_e;
   logic               r_start;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_is_md;
   logic               w_is_hl;
   logic               w_is_div;
   logic               w_busy;
   logic               w_md_stall;
   logic               w_stall;
   logic               w_issue_md;
   logic [CNT_W-1:0]   w_cnt_nxt;

   md_class_dec u_dec (
      .i_instr  (bus.instrD),
      .o_is_md  (w_is_md),
      .o_is_hl  (w_is_hl),
      .o_is_div (w_is_div)
   );

   assign w_busy     = (r_cnt != '0);
   assign w_md_stall = w_is_hl & w_busy;
   assign w_stall    = w_md_stall | bus.otherStall;
   assign w_issue_md = ~w_stall & w_is_md;

   // Load the latency on issue (start cycle included), otherwise drain to zero
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_issue_md)
         w_cnt_nxt = w_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      else if (w_busy)
         w_cnt_nxt = r_cnt - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_instr_e <= '0;
         r_start   <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_instr_e <= w_stall ? '0 : bus.instrD;
         r_start   <= w_issue_md;
         r_cnt     <= w_cnt_nxt;
      end
   end

   assign bus.instrE  = r_instr_e;
   assign bus.start   = r_start;
   assign bus.busy    = w_busy;
   assign bus.mdStall = w_md_stall;

endmodule
